// File: rtl/bsg_manycore_pkg.sv
// ---------------------------------------------------------------------------
// bsg_manycore_pkg
//
// Purpose:
//   Constants shared by the manycore endpoint FIFOs and the blocks that feed
//   them. The request throttle and its buffer take their default word width
//   from here, so a width change is made in one place only.
//
// Contents:
//   bsg_manycore_fifo_width_gp : width of one endpoint request word (bits)
// ---------------------------------------------------------------------------
package bsg_manycore_pkg;

    localparam int bsg_manycore_fifo_width_gp = 128;

endpackage

// File: rtl/bsg_manycore_fifo_req_buffer.sv
// ---------------------------------------------------------------------------
// bsg_manycore_fifo_req_buffer
//
// Purpose:
//   Small circular request buffer with an explicit occupancy counter. It has
//   no empty bypass: a word written in one cycle is visible on the output the
//   next cycle at the earliest. It also has no full bypass: ready_o is low
//   while full, even if a word leaves in the same cycle.
//
// Ports:
//   clk_i      in   clock
//   reset_n_i  in   asynchronous active-low reset (pointers and count -> 0)
//   data_i     in   incoming word
//   v_i        in   incoming word valid
//   ready_o    out  buffer has room (registered count only)
//   data_o     out  oldest buffered word
//   v_o        out  buffer is not empty
//   ready_i    in   consumer takes data_o this cycle
//   count_o    out  current occupancy, 0..els_p
// ---------------------------------------------------------------------------
module bsg_manycore_fifo_req_buffer
    import bsg_manycore_pkg::*;
#(
    parameter int width_p = bsg_manycore_fifo_width_gp,
    parameter int els_p   = 4,
    localparam int ptr_width_lp   = $clog2(els_p),
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      v_i,
    output logic                      ready_o,
    output logic [width_p-1:0]        data_o,
    output logic                      v_o,
    input  logic                      ready_i,
    output logic [count_width_lp-1:0] count_o
);

    localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      enq, deq;

    assign ready_o = (count_q != full_count_lp);
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign enq = v_i & ready_o;
    assign deq = v_o & ready_i;

    // Pointers advance independently and wrap naturally because els_p is a
    // power of two; the count only moves when exactly one side fires.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + count_width_lp'(1);
            2'b01:   count_d = count_q - count_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; an asynchronous reset empties the buffer and discards
    // whatever words it was holding.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array needs no reset: the count decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    count_within_depth_a: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) count_q <= full_count_lp
    );

endmodule

// File: rtl/bsg_manycore_fifo_req_throttle.sv
// ---------------------------------------------------------------------------
// bsg_manycore_fifo_req_throttle
//
// Purpose:
//   Credit-aware request buffer placed in front of the endpoint_req port of
//   bsg_manycore_endpoint_to_fifos_aligned. Words from the producer are
//   buffered and only presented to the endpoint while enough out-credits are
//   available. A fence drains the buffer and waits for every credit to come
//   back. A saturating counter records cycles lost to credit starvation.
//
// Ports:
//   clk_i           in   clock
//   reset_n_i       in   asynchronous active-low reset
//   in_data_i       in   request word from the producer
//   in_v_i          in   producer valid
//   in_ready_o      out  word accepted when in_v_i is high (registered state only)
//   out_data_o      out  word toward the endpoint
//   out_v_o         out  word valid toward the endpoint
//   out_ready_i     in   endpoint ready
//   out_credits_i   in   endpoint out-credit count
//   fence_i         in   one-cycle fence request
//   fence_busy_o    out  fence in progress
//   fence_done_o    out  one-cycle pulse when the fence completes
//   clear_stats_i   in   synchronous clear of the stall counter
//   count_o         out  buffer occupancy
//   stall_cycles_o  out  saturating count of credit-stall cycles
// ---------------------------------------------------------------------------
module bsg_manycore_fifo_req_throttle
    import bsg_manycore_pkg::*;
#(
    parameter int fifo_width_p      = bsg_manycore_fifo_width_gp,
    parameter int els_p             = 4,
    parameter int max_out_credits_p = 32,
    parameter int min_credits_p     = 1,
    parameter int stat_width_p      = 32,
    localparam int credit_counter_width_lp = $clog2(max_out_credits_p + 1),
    localparam int count_width_lp          = $clog2(els_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [fifo_width_p-1:0]            in_data_i,
    input  logic                               in_v_i,
    output logic                               in_ready_o,
    output logic [fifo_width_p-1:0]            out_data_o,
    output logic                               out_v_o,
    input  logic                               out_ready_i,
    input  logic [credit_counter_width_lp-1:0] out_credits_i,
    input  logic                               fence_i,
    output logic                               fence_busy_o,
    output logic                               fence_done_o,
    input  logic                               clear_stats_i,
    output logic [count_width_lp-1:0]          count_o,
    output logic [stat_width_p-1:0]            stall_cycles_o
);

    localparam logic [credit_counter_width_lp-1:0] min_credits_lp =
        credit_counter_width_lp'(min_credits_p);
    localparam logic [credit_counter_width_lp-1:0] max_credits_lp =
        credit_counter_width_lp'(max_out_credits_p);

    typedef enum logic {
        IDLE,
        FENCE
    } fence_state_e;

    fence_state_e            state_q, state_d;
    logic                    fence_done_q, fence_done_d;
    logic [stat_width_p-1:0] stall_q, stall_d;

    logic credit_ok;
    logic accepting;
    logic buf_ready;
    logic buf_v;

    assign credit_ok = (out_credits_i >= min_credits_lp);
    assign accepting = (state_q == IDLE);

    // The fence gates the producer side only; the endpoint side keeps
    // draining so the fence can finish.
    bsg_manycore_fifo_req_buffer #(
        .width_p (fifo_width_p),
        .els_p   (els_p)
    ) buffer_u (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (in_data_i),
        .v_i       (in_v_i & accepting),
        .ready_o   (buf_ready),
        .data_o    (out_data_o),
        .v_o       (buf_v),
        .ready_i   (out_ready_i & credit_ok),
        .count_o   (count_o)
    );

    assign in_ready_o     = buf_ready & accepting;
    assign out_v_o        = buf_v & credit_ok;
    assign fence_busy_o   = (state_q == FENCE);
    assign fence_done_o   = fence_done_q;
    assign stall_cycles_o = stall_q;

    // Fence sequencing. A fence is complete only once the buffer is empty
    // and every credit has come home, i.e. nothing is left in flight.
    // fence_i arriving during a fence is simply ignored.
    always_comb begin
        state_d      = state_q;
        fence_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fence_i) begin
                    state_d = FENCE;
                end
            end
            FENCE: begin
                if ((count_o == '0) && (out_credits_i == max_credits_lp)) begin
                    state_d      = IDLE;
                    fence_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall statistic: a cycle counts as stalled when there is work waiting
    // but the endpoint lacks credits. Clear wins over increment, and the
    // counter sticks at all-ones instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        if (clear_stats_i) begin
            stall_d = '0;
        end else if (buf_v && !credit_ok && !(&stall_q)) begin
            stall_d = stall_q + stat_width_p'(1);
        end
    end

    // Registered fence state, done pulse and statistic.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            fence_done_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            fence_done_q <= fence_done_d;
            stall_q      <= stall_d;
        end
    end

    credits_in_range_a: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) out_credits_i <= max_credits_lp
    );

    producer_holds_offer_a: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (in_v_i && !in_ready_o) |=> (in_v_i && $stable(in_data_i))
    );

endmodule

// File: tb/tb_bsg_manycore_fifo_req_throttle.sv
// ---------------------------------------------------------------------------
// tb_bsg_manycore_fifo_req_throttle
//
// Purpose:
//   Self-checking bench for the request throttle. A reference model kept as
//   a queue of words plus a few integers predicts every output; a monitor
//   on the falling edge compares the DUT against it and pops the expected
//   word queue whenever a word is handed to the endpoint.
// ---------------------------------------------------------------------------
module tb_bsg_manycore_fifo_req_throttle;

    localparam int W       = 128;
    localparam int ELS     = 4;
    localparam int MAXC    = 32;
    localparam int MINC    = 1;
    localparam int SW      = 4;
    localparam int SAT     = (1 << SW) - 1;
    localparam int CW      = $clog2(MAXC + 1);
    localparam int NW      = $clog2(ELS + 1);

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [W-1:0]  in_data_i;
    logic          in_v_i;
    logic          in_ready_o;
    logic [W-1:0]  out_data_o;
    logic          out_v_o;
    logic          out_ready_i;
    logic [CW-1:0] out_credits_i;
    logic          fence_i;
    logic          fence_busy_o;
    logic          fence_done_o;
    logic          clear_stats_i;
    logic [NW-1:0] count_o;
    logic [SW-1:0] stall_cycles_o;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] sbQ[$];
    bit           mFencing = 1'b0;
    bit           mDone    = 1'b0;
    int           mStall   = 0;
    bit           pending  = 1'b0;

    bsg_manycore_fifo_req_throttle #(
        .fifo_width_p      (W),
        .els_p             (ELS),
        .max_out_credits_p (MAXC),
        .min_credits_p     (MINC),
        .stat_width_p      (SW)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .in_data_i      (in_data_i),
        .in_v_i         (in_v_i),
        .in_ready_o     (in_ready_o),
        .out_data_o     (out_data_o),
        .out_v_o        (out_v_o),
        .out_ready_i    (out_ready_i),
        .out_credits_i  (out_credits_i),
        .fence_i        (fence_i),
        .fence_busy_o   (fence_busy_o),
        .fence_done_o   (fence_done_o),
        .clear_stats_i  (clear_stats_i),
        .count_o        (count_o),
        .stall_cycles_o (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus, driven just after the rising edge. A producer
    // offer that was refused is held unchanged until it is taken.
    task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit rdy,
                                 input int cr, input bit fen, input bit clr);
        @(posedge clk_i);
        #1;
        if (!pending) begin
            in_v_i    = v;
            in_data_i = d;
        end
        out_ready_i   = rdy;
        out_credits_i = CW'(cr);
        fence_i       = fen;
        clear_stats_i = clr;
    endtask

    // Monitor and reference model. The model is an ordered queue of buffered
    // words, a fencing flag, a done flag and a stall integer; outputs are
    // derived from those, then the model advances by one clock.
    always @(negedge clk_i) begin : monitor
        bit creditOk;
        bit expReady;
        bit expV;
        bit enq;
        bit deq;
        int sz;

        if (!reset_n_i) begin
            sbQ.delete();
            mFencing = 1'b0;
            mDone    = 1'b0;
            mStall   = 0;
        end

        sz       = sbQ.size();
        creditOk = (int'(out_credits_i) >= MINC);
        expReady = (sz != ELS) && !mFencing;
        expV     = (sz != 0) && creditOk;

        checkOutput("in_ready", W'(in_ready_o), W'(expReady));
        checkOutput("out_v", W'(out_v_o), W'(expV));
        checkOutput("count", W'(count_o), W'(sz));
        checkOutput("fence_busy", W'(fence_busy_o), W'(mFencing));
        checkOutput("fence_done", W'(fence_done_o), W'(mDone));
        checkOutput("stall_cycles", W'(stall_cycles_o), W'(mStall));
        if (expV) begin
            checkOutput("out_data", out_data_o, sbQ[0]);
        end

        pending = reset_n_i && in_v_i && !expReady;

        if (reset_n_i) begin
            enq = in_v_i && expReady;
            deq = expV && out_ready_i;

            if (clear_stats_i) begin
                mStall = 0;
            end else if ((sz != 0) && !creditOk && (mStall < SAT)) begin
                mStall = mStall + 1;
            end

            if (mFencing) begin
                mDone = (sz == 0) && (int'(out_credits_i) == MAXC);
                if (mDone) begin
                    mFencing = 1'b0;
                end
            end else begin
                mDone = 1'b0;
                if (fence_i) begin
                    mFencing = 1'b1;
                end
            end

            if (deq) begin
                void'(sbQ.pop_front());
            end
            if (enq) begin
                sbQ.push_back(in_data_i);
            end
        end
    end

    // Directed scenarios first, then a long randomized run.
    initial begin
        reset_n_i     = 1'b0;
        in_v_i        = 1'b1;
        in_data_i     = W'(32'hA5);
        out_ready_i   = 1'b0;
        out_credits_i = CW'(MAXC);
        fence_i       = 1'b0;
        clear_stats_i = 1'b0;

        // Reset with a valid offer present, then the first word goes in.
        repeat (3) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        applyStimulus(0, '0, 0, MAXC, 0, 0);

        // Fill to full with the endpoint stalled, then stream through.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, W'(32'h10 + i), 0, MAXC, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, W'(32'h100 + i), 1, MAXC, 0, 0);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, '0, 1, MAXC, 0, 0);
        end

        // Credit starvation with two words waiting, then recovery and clear.
        applyStimulus(1, W'(32'h200), 0, MAXC, 0, 0);
        applyStimulus(1, W'(32'h201), 0, MAXC, 0, 0);
        applyStimulus(0, '0, 0, MAXC, 0, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, '0, 1, 0, 0, 0);
        end
        applyStimulus(0, '0, 1, 5, 0, 0);
        @(negedge clk_i);
        checkOutput("stall_after_10", W'(stall_cycles_o), W'(10));
        applyStimulus(0, '0, 1, 5, 0, 0);
        applyStimulus(0, '0, 1, 5, 0, 1);
        applyStimulus(0, '0, 1, MAXC, 0, 0);

        // Saturation: twenty starved cycles on a four-bit counter.
        applyStimulus(1, W'(32'h300), 0, MAXC, 0, 0);
        applyStimulus(1, W'(32'h301), 0, MAXC, 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, '0, 1, 0, 0, 0);
        end
        applyStimulus(0, '0, 1, MAXC, 0, 0);
        @(negedge clk_i);
        checkOutput("stall_saturated", W'(stall_cycles_o), W'(SAT));
        applyStimulus(0, '0, 1, MAXC, 0, 1);
        applyStimulus(0, '0, 1, MAXC, 0, 0);

        // Fence with three words buffered plus one accepted alongside the
        // fence request, credits short until the very end.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, W'(32'h400 + i), 0, 29, 0, 0);
        end
        applyStimulus(1, W'(32'h403), 0, 29, 1, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, W'(32'h500), 1, 29, (i == 2), 0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, W'(32'h500), 1, MAXC, 0, 0);
        end
        applyStimulus(0, '0, 1, MAXC, 0, 0);
        applyStimulus(0, '0, 1, MAXC, 0, 0);

        // Asynchronous reset in the middle of a fence with words buffered.
        applyStimulus(1, W'(32'h600), 0, 29, 0, 0);
        applyStimulus(1, W'(32'h601), 0, 29, 0, 0);
        applyStimulus(0, '0, 0, 29, 1, 0);
        applyStimulus(0, '0, 0, 29, 0, 0);
        #2;
        reset_n_i = 1'b0;
        #1;
        checkOutput("rst_in_ready", W'(in_ready_o), W'(1));
        checkOutput("rst_out_v", W'(out_v_o), W'(0));
        checkOutput("rst_count", W'(count_o), W'(0));
        checkOutput("rst_fence_busy", W'(fence_busy_o), W'(0));
        checkOutput("rst_fence_done", W'(fence_done_o), W'(0));
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, W'(32'h700 + i), 1, MAXC, 0, 0);
        end
        applyStimulus(0, '0, 1, MAXC, 0, 0);

        // Randomized traffic, credits biased toward plentiful.
        for (int i = 0; i < 3000; i++) begin
            int r;
            int cr;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                cr = int'($urandom_range(0, 2));
            end else if (r < 5) begin
                cr = int'($urandom_range(3, 31));
            end else begin
                cr = MAXC;
            end
            applyStimulus(bit'($urandom_range(0, 1)),
                          {$urandom(), $urandom(), $urandom(), $urandom()},
                          ($urandom_range(0, 3) != 0),
                          cr,
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, '0, 1, MAXC, 0, 0);
        end

        @(negedge clk_i);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_fifo_req_throttle.md
Name: bsg_manycore_fifo_req_throttle

Overview:
- Synthesizable credit-aware request buffer between a 128-bit endpoint-request producer and the endpoint_req port of bsg_manycore_endpoint_to_fifos_aligned.
- The producer is typically a DPI-emulated tile or an accelerator FSM.
- Holds up to els_p outgoing request words and releases them only while out-credits are available.
- Provides a fence operation that drains the buffer and waits for all credits to return, plus a saturating stall-cycle statistic.

Parameters:
- fifo_width_p, 128, width of one request word; must match the endpoint FIFO width.
- els_p, 4, buffer depth; power of two, >= 2.
- max_out_credits_p, 32, credit count that means "nothing outstanding".
- min_credits_p, 1, minimum out_credits_i required to issue a word; 1 <= min_credits_p <= max_out_credits_p.
- stat_width_p, 32, width of the stall counter.
- credit_counter_width_lp, $clog2(max_out_credits_p+1), derived.
- count_width_lp, $clog2(els_p+1), derived.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- in_data_i  in  fifo_width_p  request word from the producer.
- in_v_i  in  1  producer valid.
- in_ready_o  out  1  buffer accepts a word (valid-ready).
- out_data_o  out  fifo_width_p  word to endpoint_req_i.
- out_v_o  out  1  word valid toward the endpoint.
- out_ready_i  in  1  endpoint_req_ready_o.
- out_credits_i  in  credit_counter_width_lp  endpoint out_credits_o.
- fence_i  in  1  one-cycle fence request.
- fence_busy_o  out  1  fence in progress.
- fence_done_o  out  1  one-cycle pulse when a fence completes.
- clear_stats_i  in  1  synchronous clear of the stall counter.
- count_o  out  count_width_lp  current occupancy.
- stall_cycles_o  out  stat_width_p  saturating credit-stall cycle count.

Behaviour:
- Reset (reset_n_i=0, asynchronous): pointers=0, count=0, state=IDLE, stall counter=0, fence_done_o=0.
- Resulting outputs in reset: out_v_o=0, in_ready_o=1, fence_busy_o=0, count_o=0, stall_cycles_o=0.
- Reset mid-operation discards buffered words. No attempt is made to recall words already sent.
- Buffer: circular array, wr_ptr/rd_ptr of log2(els_p) bits wrapping naturally, plus an explicit count register.
  - enq = in_v_i & in_ready_o; deq = out_v_o & out_ready_i.
  - Both enq and deq in the same cycle: count unchanged, both pointers advance.
- in_ready_o = (count != els_p) & (state == IDLE). It depends on registered state only; there is no combinational path from out_ready_i.
  - When full, in_ready_o=0 even if a dequeue happens that cycle (no full bypass).
- No empty bypass: a word accepted in cycle N is visible on out_v_o at N+1 at the earliest.
- credit_ok = (out_credits_i >= min_credits_p).
- out_v_o = (count != 0) & credit_ok. out_data_o = mem[rd_ptr]. Data is stable while out_v_o=1 and out_ready_i=0.
  - If credits drop below the threshold while out_v_o=1, out_v_o deasserts. This is legal because the endpoint samples only on ready.
- At most one word is issued per cycle.
- FSM states:
  - IDLE: fence_i=1 -> FENCE; fence_busy_o=1 starting the next cycle.
  - FENCE: in_ready_o=0; the buffer keeps draining. When count==0 and out_credits_i==max_out_credits_p: go to IDLE and assert fence_done_o for exactly that transition cycle. The fence may complete in the cycle after it was entered.
  - fence_i is ignored while in FENCE.
  - fence_i in the same cycle as an enq: the enq word is accepted and is drained by the fence.
- Stall counter: increments when (count != 0) & !credit_ok. Saturates at all-ones.
  - clear_stats_i has priority over increment: the value becomes 0 the next cycle.
- count_o mirrors the count register.
- Credit arithmetic is unsigned, width credit_counter_width_lp. out_credits_i > max_out_credits_p never occurs; if it does, behaviour is unspecified and an assertion fires.
- Assertions (non-synth):
  - in_v_i must not drop or change data while in_ready_o=0 and in_v_i=1.
  - count <= els_p at all times.

Decomposition:
- bsg_manycore_pkg gains bsg_manycore_fifo_width_gp=128, shared by the endpoint FIFOs and this block.
- Fence FSM state enum {IDLE, FENCE} stays local to the module.
- Sub-module bsg_manycore_fifo_req_buffer holds the circular array, pointers and count (ports v/ready/data in and out).
- The top level adds credit gating, the FSM and the statistic.

Test Plan:
- Reset with in_v_i=1 -> in_ready_o=1, out_v_o=0, count_o=0. First enq of 0xA5 shows on out_data_o the next cycle with out_v_o=1.
- Fill 4 words with out_ready_i=0 -> count_o=4, in_ready_o=0. Then out_ready_i=1 with in_v_i=1 -> 4 words exit in order, no word accepted in the full cycle, throughput 1 per cycle afterwards.
- out_credits_i=0 with 2 words buffered for 10 cycles -> out_v_o=0 and stall_cycles_o=10. Credits=5 -> both words issue. Then clear_stats_i -> stall_cycles_o=0.
- fence_i with 3 words buffered and out_credits_i=29 -> fence_busy_o=1 and in_ready_o=0 while draining. fence_done_o pulses once, in the cycle after count=0 and credits=32; fence_busy_o=0 the following cycle.
- stat_width_p=4 with 20 stall cycles -> stall_cycles_o holds at 15.
- Assert reset_n_i low mid-fence with 2 words buffered -> all outputs immediately at reset values; resumes from IDLE.
